// File: rtl/soc_status_responder.sv
// soc_status_responder: memory-mapped status register block on a
// req/gnt/rvalid core data bus. It holds the FLAG, RESULT, SCRATCH, CYCLES
// and ID registers, and it has configurable grant wait states and response
// latency.
module soc_status_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0010_0000,
  parameter int unsigned GNT_WAIT     = 0,
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        signal,
  output logic [31:0] mem_flag,
  output logic [31:0] mem_result
);

  localparam int unsigned LAT_LOAD_I = RESP_LATENCY - 1;
  localparam logic [3:0]  GNT_WAIT_C = GNT_WAIT[3:0];
  localparam logic [3:0]  LAT_LOAD   = LAT_LOAD_I[3:0];
  localparam logic [31:0] ID_VALUE   = 32'hCE5E_0001;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_next;
  logic [3:0]  lat_cnt;
  logic [3:0]  lat_next;
  logic        accept;
  logic        resp_next;

  logic [31:0] flag;
  logic [31:0] result;
  logic [31:0] scratch;
  logic [31:0] cycles;

  logic [9:0]  word_off;
  logic        hit;
  logic        err_now;
  logic [31:0] rd_now;
  logic [31:0] rd_src;
  logic [31:0] rd_cap;
  logic        err_cap;
  logic        unused_addr_bits;

  // Merge the enabled bytes of new_val into old_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_val[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_val[8*k +: 8];
      end
    end
    return res;
  endfunction

  assign unused_addr_bits = ^addr_i[1:0];
  assign accept           = req_i && gnt_o;
  assign rd_src           = we_i ? 32'h0000_0000 : rd_now;
  assign mem_flag         = flag;
  assign mem_result       = result;

  // Address decode and read mux. This uses the register values of the current cycle.
  always_comb begin
    word_off = addr_i[11:2];
    hit      = (addr_i[31:12] == BASE_ADDR[31:12]);
    err_now  = !hit || (word_off > 10'd4);
    rd_now   = 32'h0000_0000;
    if (hit) begin
      case (word_off)
        10'd0:   rd_now = flag;
        10'd1:   rd_now = result;
        10'd2:   rd_now = scratch;
        10'd3:   rd_now = cycles;
        10'd4:   rd_now = ID_VALUE;
        default: rd_now = 32'h0000_0000;
      endcase
    end else begin
      rd_now = 32'h0000_0000;
    end
  end

  // Handshake FSM: next state, the wait and latency counters, and the grant.
  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    lat_next   = lat_cnt;
    gnt_o      = 1'b0;
    resp_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt_o = rst_ni && req_i && (wait_cnt == GNT_WAIT_C);
        if (!req_i) begin
          wait_next = 4'd0;
        end else if (gnt_o) begin
          wait_next  = 4'd0;
          lat_next   = LAT_LOAD;
          state_next = ST_RESP;
          resp_next  = (LAT_LOAD == 4'd0);
        end else if (wait_cnt < GNT_WAIT_C) begin
          wait_next = wait_cnt + 4'd1;
        end else begin
          wait_next = wait_cnt;
        end
      end
      ST_RESP: begin
        wait_next = 4'd0;
        if (lat_cnt == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          lat_next  = lat_cnt - 4'd1;
          resp_next = (lat_cnt == 4'd1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        wait_next  = 4'd0;
        lat_next   = 4'd0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      lat_cnt  <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      lat_cnt  <= lat_next;
    end
  end

  // Register file. Writes commit at acceptance. CYCLES counts every clock and ignores writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flag    <= 32'h0000_0000;
      result  <= 32'h0000_0000;
      scratch <= 32'h0000_0000;
      cycles  <= 32'h0000_0000;
      signal  <= 1'b0;
    end else begin
      cycles <= cycles + 32'd1;
      signal <= (flag != 32'h0000_0000);
      if (accept && we_i && !err_now) begin
        case (word_off)
          10'd0:   flag    <= byte_merge(flag, wdata_i, be_i);
          10'd1:   result  <= byte_merge(result, wdata_i, be_i);
          10'd2:   scratch <= byte_merge(scratch, wdata_i, be_i);
          default: begin
          end
        endcase
      end
    end
  end

  // Response path. Read data is captured at acceptance, and it is presented with the registered rvalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cap   <= 32'h0000_0000;
      err_cap  <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= 32'h0000_0000;
      err_o    <= 1'b0;
    end else begin
      if (accept) begin
        rd_cap  <= rd_src;
        err_cap <= err_now;
      end
      rvalid_o <= resp_next;
      if (resp_next) begin
        rdata_o <= accept ? rd_src : rd_cap;
        err_o   <= accept ? err_now : err_cap;
      end else begin
        rdata_o <= 32'h0000_0000;
        err_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_soc_status_responder.sv
// Directed testbench for soc_status_responder. Instance A uses the default
// timing. Instance B uses GNT_WAIT=3 and RESP_LATENCY=4.
module tb_soc_status_responder;

  localparam logic [31:0] BASE = 32'h0010_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req_a, gnt_a, rvalid_a, we_a, err_a, sig_a;
  logic [3:0]  be_a;
  logic [31:0] addr_a, wdata_a, rdata_a, flag_a, result_a;
  logic        rst_b, req_b, gnt_b, rvalid_b, we_b, err_b, sig_b;
  logic [3:0]  be_b;
  logic [31:0] addr_b, wdata_b, rdata_b, flag_b, result_b;

  logic [31:0] cyc_a, cyc_b;
  int checks = 0;
  int errors = 0;

  soc_status_responder dut_a (
    .clk_i(clk), .rst_ni(rst_a), .req_i(req_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .addr_i(addr_a), .we_i(we_a), .be_i(be_a), .wdata_i(wdata_a), .rdata_o(rdata_a),
    .err_o(err_a), .signal(sig_a), .mem_flag(flag_a), .mem_result(result_a)
  );

  soc_status_responder #(.GNT_WAIT(3), .RESP_LATENCY(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .req_i(req_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .addr_i(addr_b), .we_i(we_b), .be_i(be_b), .wdata_i(wdata_b), .rdata_o(rdata_b),
    .err_o(err_b), .signal(sig_b), .mem_flag(flag_b), .mem_result(result_b)
  );

  // Reference cycle counters: clocks since each instance left reset
  always @(posedge clk or negedge rst_a) if (!rst_a) cyc_a <= 32'd0; else cyc_a <= cyc_a + 32'd1;
  always @(posedge clk or negedge rst_b) if (!rst_b) cyc_b <= 32'd0; else cyc_b <= cyc_b + 32'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b);
    if (d == 0) begin
      req_a = r; we_a = w; addr_a = a; wdata_a = wd; be_a = b;
    end else begin
      req_b = r; we_b = w; addr_b = a; wdata_b = wd; be_b = b;
    end
  endtask

  // One transfer: hold req until grant (bounded), then wait for rvalid (bounded)
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] b, output logic [31:0] rd, output logic er,
                      output int waited, output int lat, output logic [31:0] acc);
    @(negedge clk);
    drive(d, 1'b1, w, a, wd, b);
    #1;
    waited = 0;
    while (((d == 0) ? gnt_a : gnt_b) !== 1'b1 && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    acc = (d == 0) ? cyc_a : cyc_b;
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    lat = 1;
    while (((d == 0) ? rvalid_a : rvalid_b) !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = (d == 0) ? rdata_a : rdata_b;
    er = (d == 0) ? err_a : err_b;
  endtask

  logic [31:0] rd, acc, res_before;
  logic        er;
  int          w, l;
  logic [31:0] sdata [4];

  initial begin
    sdata[0] = 32'h0000_1111; sdata[1] = 32'h2222_0000;
    sdata[2] = 32'hDEAD_BEEF; sdata[3] = 32'h0BAD_F00D;
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(negedge clk);
    req_a = 1'b1;
    #1;
    chk("rst_gnt", {31'd0, gnt_a}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_signal", {31'd0, sig_a}, 32'd0);
    chk("rst_flag", flag_a, 32'd0);
    chk("rst_result", result_a, 32'd0);
    req_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;

    // Write FLAG=1, then read it back
    xfer(0, 1'b1, BASE, 32'h0000_0001, 4'hF, rd, er, w, l, acc);
    chk("flag_wr_wait", 32'(w), 32'd0);
    chk("flag_wr_lat", 32'(l), 32'd1);
    chk("flag_wr_err", {31'd0, er}, 32'd0);
    chk("mem_flag", flag_a, 32'd1);
    chk("signal_lag", {31'd0, sig_a}, 32'd0);
    @(negedge clk);
    chk("signal_set", {31'd0, sig_a}, 32'd1);
    xfer(0, 1'b0, BASE, 32'd0, 4'h0, rd, er, w, l, acc);
    chk("flag_rd", rd, 32'd1);
    @(negedge clk);
    chk("rdata_idle_zero", rdata_a, 32'd0);

    // RESULT byte-enable merge
    xfer(0, 1'b1, BASE + 32'h4, 32'hAABB_CCDD, 4'hF, rd, er, w, l, acc);
    xfer(0, 1'b1, BASE + 32'h4, 32'h1122_3344, 4'b0101, rd, er, w, l, acc);
    xfer(0, 1'b0, BASE + 32'h4, 32'd0, 4'h0, rd, er, w, l, acc);
    chk("result_rd", rd, 32'hAA22_CC44);
    chk("mem_result", result_a, 32'hAA22_CC44);

    // Errors and read-only registers
    xfer(0, 1'b0, BASE + 32'h14, 32'd0, 4'hF, rd, er, w, l, acc);
    chk("bad_off_err", {31'd0, er}, 32'd1);
    chk("bad_off_rdata", rd, 32'd0);
    res_before = result_a;
    xfer(0, 1'b1, 32'h0020_0000, 32'hFFFF_FFFF, 4'hF, rd, er, w, l, acc);
    chk("bad_base_err", {31'd0, er}, 32'd1);
    chk("bad_base_flag", flag_a, 32'd1);
    chk("bad_base_result", result_a, res_before);
    xfer(0, 1'b1, BASE + 32'hC, 32'h1234_5678, 4'hF, rd, er, w, l, acc);
    chk("cyc_wr_err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, BASE + 32'hC, 32'd0, 4'h0, rd, er, w, l, acc);
    chk("cyc_rd", rd, acc);
    xfer(0, 1'b0, BASE + 32'h10, 32'd0, 4'h0, rd, er, w, l, acc);
    chk("id_rd_a", rd, 32'hCE5E_0001);

    // Back-to-back SCRATCH writes with req held
    @(negedge clk);
    drive(0, 1'b1, 1'b1, BASE + 32'h8, sdata[0], 4'hF);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("b2b_gnt_%0d", i), {31'd0, gnt_a}, {31'd0, (i % 2) == 0});
      chk($sformatf("b2b_rvalid_%0d", i), {31'd0, rvalid_a}, {31'd0, (i % 2) == 1});
      @(negedge clk);
      if ((i % 2) == 0) wdata_a = sdata[i / 2 + 1];
      if (i == 5) drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    end
    xfer(0, 1'b0, BASE + 32'h8, 32'd0, 4'h0, rd, er, w, l, acc);
    chk("b2b_scratch", rd, sdata[2]);

    // Instance B: GNT_WAIT=3, RESP_LATENCY=4
    xfer(1, 1'b0, BASE + 32'h10, 32'd0, 4'h0, rd, er, w, l, acc);
    chk("id_wait", 32'(w), 32'd3);
    chk("id_lat", 32'(l), 32'd4);
    chk("id_rd_b", rd, 32'hCE5E_0001);
    // req held 2 cycles then dropped: no grant, and the wait count restarts
    @(negedge clk);
    drive(1, 1'b1, 1'b0, BASE + 32'h14, 32'd0, 4'h0);
    #1;
    chk("drop_gnt0", {31'd0, gnt_b}, 32'd0);
    @(negedge clk);
    addr_b = BASE + 32'h8;
    #1;
    chk("drop_gnt1", {31'd0, gnt_b}, 32'd0);
    @(negedge clk);
    req_b = 1'b0;
    xfer(1, 1'b0, BASE + 32'h10, 32'd0, 4'h0, rd, er, w, l, acc);
    chk("restart_wait", 32'(w), 32'd3);
    chk("restart_rd", rd, 32'hCE5E_0001);

    // Reset in the middle of a response
    xfer(1, 1'b1, BASE, 32'h0000_0005, 4'hF, rd, er, w, l, acc);
    chk("b_flag", flag_b, 32'd5);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, BASE + 32'h10, 32'd0, 4'h0);
    #1;
    w = 0;
    while (gnt_b !== 1'b1 && w < 40) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("mid_wait", 32'(w), 32'd3);
    @(negedge clk);
    req_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    req_b = 1'b1;
    #1;
    chk("mid_rvalid", {31'd0, rvalid_b}, 32'd0);
    chk("mid_rdata", rdata_b, 32'd0);
    chk("mid_err", {31'd0, err_b}, 32'd0);
    chk("mid_signal", {31'd0, sig_b}, 32'd0);
    chk("mid_flag", flag_b, 32'd0);
    chk("mid_result", result_b, 32'd0);
    chk("mid_gnt", {31'd0, gnt_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    req_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("post_rst_rvalid_%0d", i), {31'd0, rvalid_b}, 32'd0);
      @(negedge clk);
    end
    xfer(1, 1'b0, BASE + 32'hC, 32'd0, 4'h0, rd, er, w, l, acc);
    chk("post_rst_cycles", rd, acc);
    chk("post_rst_small", {31'd0, rd < 32'd20}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
